// File: rtl/usr_xfer_seq.sv
// Command sequencer driving an 8-bit universal shift register as a full-duplex SERDES.
// Optional USR_SEQ_PRESCALE_EN: one shift step every SHIFT_DIV cycles in SHIFT.
module usr_xfer_seq #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = $clog2(WIDTH) + 1,
    parameter int SHIFT_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             busy,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_data_in,
    output logic             usr_sl_ser,
    output logic             usr_sr_ser,
    input  logic [WIDTH-1:0] usr_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             dir_q, dir_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             accept;
    logic             step;
    logic [CNT_W-1:0] len_clamp;

    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign len_clamp = (cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;

`ifdef USR_SEQ_PRESCALE_EN
    localparam int PRE_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;

    assign step = (state_q == S_SHIFT) && (pre_q == PRE_W'(SHIFT_DIV - 1));

    // Prescaler is held at zero outside SHIFT so every entry starts a fresh period.
    always_comb begin
        pre_d = '0;
        if (state_q == S_SHIFT && !step) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = (state_q == S_SHIFT) && (SHIFT_DIV > 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (len_q != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                if (step && cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        usr_select  = 2'b11;
        usr_data_in = data_q;
        usr_sl_ser  = 1'b0;
        usr_sr_ser  = 1'b0;
        ser_out     = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                usr_select = 2'b10;
            end
            S_SHIFT: begin
                usr_select = step ? {1'b0, dir_q} : 2'b11;
                usr_sl_ser = ser_in;
                usr_sr_ser = ser_in;
                ser_out    = dir_q ? usr_data_out[0] : usr_data_out[WIDTH-1];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        dir_d       = dir_q;
        len_d       = len_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            dir_d  = cmd_dir;
            len_d  = len_clamp;
            data_d = cmd_data;
        end
        if (state_q == S_LOAD) begin
            cnt_d = len_q;
        end
        if (step) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Register settles on the DONE entry edge, so capture one cycle later.
        if (state_q == S_DONE && !rsp_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = usr_data_out;
        end
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q       <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            dir_q       <= dir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_usr_xfer_seq.sv
// Bench for usr_xfer_seq: behavioural shift register, directed and random transfers.
// Step period follows USR_SEQ_PRESCALE_EN (SHIFT_DIV = 4 when defined).
module tb_usr_xfer_seq;

`ifdef USR_SEQ_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic       clock, reset;
    logic       cmd_valid, cmd_ready, cmd_dir;
    logic [3:0] cmd_len;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       ser_in, ser_out, busy;
    logic [1:0] usr_select;
    logic [7:0] usr_data_in, usr_data_out;
    logic       usr_sl_ser, usr_sr_ser;

    int vectors = 0;
    int miscompares = 0;

    usr_xfer_seq #(.WIDTH(8), .SHIFT_DIV(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ser_in(ser_in), .ser_out(ser_out), .busy(busy),
        .usr_select(usr_select), .usr_data_in(usr_data_in),
        .usr_sl_ser(usr_sl_ser), .usr_sr_ser(usr_sr_ser),
        .usr_data_out(usr_data_out)
    );

    // Universal shift register with its own synchronous reset.
    always @(posedge clock) begin
        if (reset) usr_data_out <= 8'h00;
        else begin
            case (usr_select)
                2'b00: usr_data_out <= {usr_data_out[6:0], usr_sl_ser};
                2'b01: usr_data_out <= {usr_sr_ser, usr_data_out[7:1]};
                2'b10: usr_data_out <= usr_data_in;
                default: usr_data_out <= usr_data_out;
            endcase
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return logic'(mode[0]);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            tick();
            t++;
        end
        chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Reference: outgoing bits are the original word's bits in shift order; the
    // final word is the unshifted remainder plus the captured ser_in bits.
    task automatic xfer(input logic [7:0] data, input logic dir, input int len,
                        input int mode, input int bp);
        int         clen, n, steps;
        logic       inb[$];
        logic [7:0] exp_word, held;
        clen = (len > 8) ? 8 : len;
        steps = 0;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = 4'(len);
        cmd_data  = data;
        ser_in    = pick(mode);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        chk("load_select", 32'(usr_select), 32'h2);
        chk("load_data_in", 32'(usr_data_in), 32'(data));
        chk("load_ser_out", 32'(ser_out), 32'd0);
        chk("load_busy", {30'd0, busy, cmd_ready}, 32'h2);
        n = 0;
        while (!rsp_valid && n < 200) begin
            ser_in = pick(mode);
            if (usr_select == {1'b0, dir}) begin
                chk("ser_out_bit", 32'(ser_out),
                    32'(dir ? data[steps & 7] : data[7 - (steps & 7)]));
                inb.push_back(ser_in);
                steps++;
            end
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(2 + clen * DIV));
        chk("step_count", 32'(steps), 32'(clen));
        if (dir) begin
            exp_word = data >> clen;
            for (int j = 0; j < clen; j++) exp_word[8 - clen + j] = inb[j];
        end else begin
            exp_word = data << clen;
            for (int j = 0; j < clen; j++) exp_word[clen - 1 - j] = inb[j];
        end
        chk("rsp_data", 32'(rsp_data), 32'(exp_word));
        chk("done_select", 32'(usr_select), 32'h3);
        held = rsp_data;
        for (int k = 0; k < bp; k++) begin
            tick();
            chk("bp_hold", {23'd0, rsp_valid, cmd_ready, rsp_data}, {23'd0, 2'b10, held});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("after_handshake", {30'd0, rsp_valid, cmd_ready}, 32'h1);
    endtask

    initial begin
        int   n, steps;
        logic leaked;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_len = 4'd0;
        cmd_data = 8'h00;
        rsp_ready = 1'b0;
        ser_in = 1'b1;
        #2;
        chk("rst_handshake", {29'd0, cmd_ready, rsp_valid, busy}, 32'h4);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_select", 32'(usr_select), 32'h3);
        chk("rst_serial", {29'd0, ser_out, usr_sl_ser, usr_sr_ser}, 32'h0);
        chk("rst_data_in", 32'(usr_data_in), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        xfer(8'hA5, 1'b0, 8, 0, 0);
        xfer(8'hA5, 1'b1, 4, 1, 0);
        xfer(8'h3C, 1'b0, 0, 0, 0);
        xfer(8'h81, 1'b0, 15, 1, 5);
        xfer(8'h80, 1'b0, 2, 0, 0);
        xfer(8'h5A, 1'b1, 8, 2, 1);

        // Abort during the third shift step of a full-length transfer.
        wait_idle();
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_len = 4'd8;
        cmd_data = 8'hC3;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        steps = 0;
        while (steps < 3 && n < 100) begin
            if (usr_select == 2'b00) steps++;
            if (steps < 3) begin
                tick();
                n++;
            end
        end
        chk("abort_reached_step3", 32'(steps), 32'd3);
        reset = 1'b1;
        #1;
        chk("abort_state", {29'd0, cmd_ready, rsp_valid, busy}, 32'h4);
        chk("abort_select", 32'(usr_select), 32'h3);
        chk("abort_ser_out", 32'(ser_out), 32'h0);
        tick();
        reset = 1'b0;
        leaked = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            leaked |= rsp_valid | busy;
        end
        chk("abort_no_response", 32'(leaked), 32'd0);

        for (int r = 0; r < 20; r++) begin
            xfer(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 2, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_xfer_seq.md
Name: usr_xfer_seq

Overview:
- Command-driven sequencer for the 8-bit universal shift register (select codes 00 shift-left, 01 shift-right, 10 parallel load, 11 hold).
- Accepts a transfer command, parallel-loads the register, then shifts it 0..WIDTH times while driving the outgoing serial bit and feeding the incoming serial bit. This makes the register a full-duplex serializer/deserializer.
- Returns the final register contents through a valid/ready response.
- Sits between user logic (or a wishbone/IO front end) and the shift register instance.

Parameters:
- WIDTH, 8, shift register width; must match the datapath instance.
- CNT_W, $clog2(WIDTH)+1, width of the length field and the bit counter.
- SHIFT_DIV, 4, cycles per shift step; used only when USR_SEQ_PRESCALE_EN is defined; legal values are 1 or greater.

Ports:
- clock  in  1  single block clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command (IDLE only).
- cmd_dir  in  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
- cmd_len  in  CNT_W  number of shift steps; 0 = load only; values above WIDTH are clamped to WIDTH.
- cmd_data  in  WIDTH  word to parallel-load.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  register contents after the final shift.
- ser_in  in  1  incoming serial bit, sampled on each shift step.
- ser_out  out  1  outgoing serial bit.
- busy  out  1  high in any state other than IDLE.
- usr_select  out  2  to shift register select.
- usr_data_in  out  WIDTH  to shift register parallel input.
- usr_sl_ser  out  1  to shift register left-shift serial input.
- usr_sr_ser  out  1  to shift register right-shift serial input.
- usr_data_out  in  WIDTH  from shift register output.

Behaviour:
- Reset values (asynchronous, while reset is high):
  - state = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_data = 0; busy = 0; ser_out = 0.
  - usr_select = 11; usr_data_in = 0; usr_sl_ser = 0; usr_sr_ser = 0.
  - Internal counter and latched dir/len/data = 0.
- The shift register resets synchronously on its own. The sequencer never relies on the register's contents before a LOAD.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1, usr_select = 11.
  - When cmd_valid and cmd_ready are both high on an edge: latch dir, clamped len, and data; go to LOAD.
- LOAD (exactly 1 cycle):
  - usr_select = 10, usr_data_in = latched data. The register holds the data at the next edge.
  - Next state is SHIFT if len > 0, otherwise DONE.
- SHIFT:
  - Each step asserts usr_select = 00 (dir 0) or 01 (dir 1) for one cycle.
  - usr_sl_ser = usr_sr_ser = ser_in (combinational pass-through).
  - ser_out = usr_data_out[WIDTH-1] for dir 0, usr_data_out[0] for dir 1. It is valid in the cycle before the shifting edge, and 0 outside SHIFT.
  - The counter is loaded with len on entry and decrements per step. After the step that takes it to 0, go to DONE.
  - SHIFT lasts exactly len cycles.
- DONE:
  - usr_select = 11 (hold).
  - rsp_valid = 1 and rsp_data = usr_data_out, sampled on entry and held stable until the handshake.
  - On rsp_valid and rsp_ready high: go to IDLE and drop rsp_valid. No command is accepted in DONE.
- Latency: command accept to rsp_valid = 2 + len cycles (no prescale).
- Back-to-back: a response consumed at edge N allows a new command accept at edge N+1. A command held high is ignored until IDLE.
- Reset mid-operation: abort immediately to the reset values. No response is issued for the aborted command.
- cmd_len above WIDTH is clamped at accept. A WIDTH-step transfer fully replaces the register with ser_in bits.

Optional Feature:
- Macro: USR_SEQ_PRESCALE_EN.
- When defined:
  - A prescale counter runs in SHIFT, and a shift step occurs only on every SHIFT_DIV-th cycle.
  - usr_select = 11 on non-step cycles.
  - ser_out holds the current outgoing bit for the whole SHIFT_DIV period.
  - The prescale counter clears on entry to SHIFT and on reset.
  - Latency becomes 2 + len*SHIFT_DIV.
- When undefined: a step on every SHIFT cycle, and SHIFT_DIV is ignored.

Test Plan:
- Left full transfer: cmd_data = 0xA5, dir 0, len 8, ser_in = 0 -> ser_out sequence 1,0,1,0,0,1,0,1; rsp_data = 0x00; rsp_valid 10 cycles after accept.
- Right partial transfer: 0xA5, dir 1, len 4, ser_in = 1 -> ser_out 1,0,1,0; rsp_data = 0xFA.
- Load only: 0x3C, len 0 -> usr_select sequence 10 then 11; rsp_valid 2 cycles after accept; rsp_data = 0x3C; ser_out stays 0.
- Clamp plus backpressure: 0x81, dir 0, len 15, ser_in = 1, rsp_ready held low 5 cycles -> exactly 8 steps; rsp_data = 0xFF held stable; cmd_ready = 0 until the handshake, then 1 the next cycle.
- Reset mid-shift: assert reset during step 3 of a len-8 transfer -> immediately state IDLE, usr_select = 11, rsp_valid = 0, cmd_ready = 1; no response.
- Prescale (macro defined, SHIFT_DIV = 4): 0x80, dir 0, len 2, ser_in = 0 -> usr_select 00 every 4th SHIFT cycle; ser_out = 1 for 4 cycles then 0 for 4 cycles; rsp_data = 0x00; latency 10 cycles.
